// File: rtl/noc_pkg.sv
// Shared constants and helpers for the one-hot gather/distribute node family.
package noc_pkg;

   localparam int NOC_DATA_WIDTH = 32;
   localparam logic [NOC_DATA_WIDTH-1:0] DUMMY_DATA = '0;
   localparam int FIFO_DEPTH = 2;

   // Each merge stage appends one one-hot source bit below the inbound command.
   function automatic int out_cmd_width(input int in_width);
      return in_width + 1;
   endfunction

endpackage

// File: rtl/noc_skid_fifo2.sv
// Two-entry valid/ready buffer with a registered head; the head holds its last
// value when the buffer empties.
module noc_skid_fifo2
   import noc_pkg::*;
#(
   parameter int WIDTH = 35
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [1:0]       count,
   output logic [WIDTH-1:0] head
);

   logic [WIDTH-1:0] tail;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && (count < 2'(FIFO_DEPTH));
   assign do_pop  = pop && (count != 2'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= 2'd0;
         head  <= '0;
         tail  <= '0;
      end else begin
         case ({do_push, do_pop})
            2'b10: begin
               if (count == 2'd0) head <= push_data;
               else               tail <= push_data;
               count <= count + 2'd1;
            end
            2'b01: begin
               if (count == 2'd2) head <= tail;
               count <= count - 2'd1;
            end
            2'b11: begin
               // Count is unchanged; with a single entry the new word goes straight to the head.
               if (count == 2'd1) begin
                  head <= push_data;
               end else begin
                  head <= tail;
                  tail <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/collect_2x1_one_hot_pipe.sv
// Gather-chain merge node: round-robin between chain and local ports, tags the
// source in cmd bit 0 and buffers two entries toward the output.
module collect_2x1_one_hot_pipe
   import noc_pkg::*;
#(
   parameter int DATA_WIDTH       = 32,
   parameter int IN_COMMAND_WIDTH = 2
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic                                      i_en,
   input  logic                                      i_chain_valid,
   input  logic [DATA_WIDTH-1:0]                     i_chain_data_bus,
   input  logic [IN_COMMAND_WIDTH-1:0]               i_chain_cmd,
   output logic                                      o_chain_ready,
   input  logic                                      i_local_valid,
   input  logic [DATA_WIDTH-1:0]                     i_local_data_bus,
   output logic                                      o_local_ready,
   output logic                                      o_valid,
   output logic [DATA_WIDTH-1:0]                     o_data_bus,
   output logic [out_cmd_width(IN_COMMAND_WIDTH)-1:0] o_cmd,
   input  logic                                      i_ready
);

   localparam int OUT_COMMAND_WIDTH = out_cmd_width(IN_COMMAND_WIDTH);
   localparam int ENTRY_WIDTH       = DATA_WIDTH + OUT_COMMAND_WIDTH;
   localparam logic [DATA_WIDTH-1:0] IDLE_DATA = DATA_WIDTH'(DUMMY_DATA);

   logic [1:0]             count;
   logic [ENTRY_WIDTH-1:0] head;
   logic [ENTRY_WIDTH-1:0] push_data;
   logic                   rr;
   logic                   grant_ok;
   logic                   chain_go;
   logic                   local_go;

   // Space comes from the registered count only, so a pop never frees a slot in the same cycle.
   assign grant_ok = rst_n && i_en && (count < 2'(FIFO_DEPTH));

   assign o_chain_ready = grant_ok && i_chain_valid && (!i_local_valid || !rr);
   assign o_local_ready = grant_ok && i_local_valid && (!i_chain_valid || rr);
   assign chain_go      = o_chain_ready;
   assign local_go      = o_local_ready;

   always_comb begin
      push_data = {IDLE_DATA, {OUT_COMMAND_WIDTH{1'b0}}};
      if (chain_go)
         push_data = {i_chain_data_bus, i_chain_cmd, 1'b0};
      else if (local_go)
         push_data = {i_local_data_bus, {IN_COMMAND_WIDTH{1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        rr <= 1'b0;
      else if (chain_go) rr <= 1'b1;
      else if (local_go) rr <= 1'b0;
   end

   noc_skid_fifo2 #(
      .WIDTH(ENTRY_WIDTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (chain_go || local_go),
      .push_data(push_data),
      .pop      (o_valid && i_ready),
      .count    (count),
      .head     (head)
   );

   assign o_valid    = (count != 2'd0);
   assign o_data_bus = head[ENTRY_WIDTH-1:OUT_COMMAND_WIDTH];
   assign o_cmd      = head[OUT_COMMAND_WIDTH-1:0];

endmodule

// File: tb/tb_collect_2x1_one_hot_pipe.sv
// Self-checking bench: queue-based reference model checked every cycle plus
// directed scenarios with literal expectations.
module tb_collect_2x1_one_hot_pipe;

   localparam int DW  = 32;
   localparam int ICW = 2;
   localparam int OCW = 3;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           i_en;
   logic           i_chain_valid;
   logic [DW-1:0]  i_chain_data_bus;
   logic [ICW-1:0] i_chain_cmd;
   logic           o_chain_ready;
   logic           i_local_valid;
   logic [DW-1:0]  i_local_data_bus;
   logic           o_local_ready;
   logic           o_valid;
   logic [DW-1:0]  o_data_bus;
   logic [OCW-1:0] o_cmd;
   logic           i_ready;

   int checks   = 0;
   int failures = 0;

   collect_2x1_one_hot_pipe #(.DATA_WIDTH(DW), .IN_COMMAND_WIDTH(ICW)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_en            (i_en),
      .i_chain_valid   (i_chain_valid),
      .i_chain_data_bus(i_chain_data_bus),
      .i_chain_cmd     (i_chain_cmd),
      .o_chain_ready   (o_chain_ready),
      .i_local_valid   (i_local_valid),
      .i_local_data_bus(i_local_data_bus),
      .o_local_ready   (o_local_ready),
      .o_valid         (o_valid),
      .o_data_bus      (o_data_bus),
      .o_cmd           (o_cmd),
      .i_ready         (i_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: stored words in arrival order, and which port the arbiter favours.
   logic [DW+OCW-1:0] mq[$];
   bit                m_favour_local = 0;
   logic [DW+OCW-1:0] out_log[$];

   function automatic bit m_chain_grant();
      return rst_n && i_en && (mq.size() < 2) && i_chain_valid
             && (!i_local_valid || !m_favour_local);
   endfunction

   function automatic bit m_local_grant();
      return rst_n && i_en && (mq.size() < 2) && i_local_valid
             && (!i_chain_valid || m_favour_local);
   endfunction

   always @(negedge rst_n) begin
      mq.delete();
      m_favour_local = 0;
   end

   always @(posedge clk) begin
      if (rst_n) begin
         bit cg, lg;
         cg = m_chain_grant();
         lg = m_local_grant();
         if (mq.size() != 0 && i_ready) void'(mq.pop_front());
         if (cg) begin
            mq.push_back({i_chain_data_bus, i_chain_cmd, 1'b0});
            m_favour_local = 1;
         end else if (lg) begin
            mq.push_back({i_local_data_bus, {ICW{1'b0}}, 1'b1});
            m_favour_local = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_valid", 64'(o_valid), 64'd0);
         chk("rst_data", 64'(o_data_bus), 64'd0);
         chk("rst_cmd", 64'(o_cmd), 64'd0);
         chk("rst_readys", 64'({o_chain_ready, o_local_ready}), 64'd0);
      end else begin
         chk("valid", 64'(o_valid), 64'(mq.size() != 0));
         chk("chain_ready", 64'(o_chain_ready), 64'(m_chain_grant()));
         chk("local_ready", 64'(o_local_ready), 64'(m_local_grant()));
         if (mq.size() != 0) begin
            chk("head_data", 64'(o_data_bus), 64'(mq[0][DW+OCW-1:OCW]));
            chk("head_cmd", 64'(o_cmd), 64'(mq[0][OCW-1:0]));
         end
         if (o_valid && i_ready) out_log.push_back({o_data_bus, o_cmd});
      end
   end

   task automatic send_chain(input logic [DW-1:0] d, input logic [ICW-1:0] c);
      int budget = 50;
      i_chain_valid = 1'b1; i_chain_data_bus = d; i_chain_cmd = c;
      @(negedge clk);
      while (!o_chain_ready && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (budget == 0) chk("chain_timeout", 64'd1, 64'd0);
      @(posedge clk); #1;
      i_chain_valid = 1'b0;
   endtask

   task automatic send_local(input logic [DW-1:0] d);
      int budget = 50;
      i_local_valid = 1'b1; i_local_data_bus = d;
      @(negedge clk);
      while (!o_local_ready && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (budget == 0) chk("local_timeout", 64'd1, 64'd0);
      @(posedge clk); #1;
      i_local_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [DW+OCW-1:0] exp_seq[$];
      int grants;
      rst_n = 1'b0; i_en = 1'b1; i_ready = 1'b1;
      i_chain_valid = 1'b0; i_chain_data_bus = '0; i_chain_cmd = '0;
      i_local_valid = 1'b0; i_local_data_bus = '0;
      idle(2);
      rst_n = 1'b1;

      // Single chain word appears one cycle after the transfer edge.
      send_chain(32'h1111_1111, 2'b10);
      @(negedge clk);
      chk("t1_valid", 64'(o_valid), 64'd1);
      chk("t1_data", 64'(o_data_bus), 64'h1111_1111);
      chk("t1_cmd", 64'(o_cmd), 64'b100);
      idle(2);

      send_local(32'h2222_2222);
      @(negedge clk);
      chk("t2_data", 64'(o_data_bus), 64'h2222_2222);
      chk("t2_cmd", 64'(o_cmd), 64'b001);
      chk("t2_chain_ready", 64'(o_chain_ready), 64'd0);
      idle(3);

      // Both ports always valid: strict alternation starting with chain.
      out_log.delete();
      i_chain_valid = 1'b1; i_chain_data_bus = 32'hAAAA_AAAA; i_chain_cmd = 2'b01;
      i_local_valid = 1'b1; i_local_data_bus = 32'hBBBB_BBBB;
      grants = 0;
      for (int cyc = 0; cyc < 20 && grants < 6; cyc++) begin
         @(negedge clk);
         if (o_chain_ready || o_local_ready) grants++;
         @(posedge clk); #1;
      end
      chk("t3_grants", 64'(grants), 64'd6);
      i_chain_valid = 1'b0; i_local_valid = 1'b0;
      idle(4);
      exp_seq = '{{32'hAAAA_AAAA, 3'b010}, {32'hBBBB_BBBB, 3'b001},
                  {32'hAAAA_AAAA, 3'b010}, {32'hBBBB_BBBB, 3'b001},
                  {32'hAAAA_AAAA, 3'b010}, {32'hBBBB_BBBB, 3'b001}};
      chk("t3_count", 64'(out_log.size()), 64'd6);
      for (int k = 0; k < 6 && k < out_log.size(); k++)
         chk($sformatf("t3_word%0d", k), 64'(out_log[k]), 64'(exp_seq[k]));

      // Backpressure: two words fit, the third is stalled until the sink drains.
      out_log.delete();
      i_ready = 1'b0;
      send_chain(32'h1, 2'b01);
      send_chain(32'h2, 2'b01);
      i_chain_valid = 1'b1; i_chain_data_bus = 32'h3; i_chain_cmd = 2'b01;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t4_full_ready", 64'(o_chain_ready), 64'd0);
         chk("t4_full_valid", 64'(o_valid), 64'd1);
      end
      @(posedge clk); #1;
      i_ready = 1'b1;
      send_chain(32'h3, 2'b01);
      idle(4);
      exp_seq = '{{32'h1, 3'b010}, {32'h2, 3'b010}, {32'h3, 3'b010}};
      chk("t4_count", 64'(out_log.size()), 64'd3);
      for (int k = 0; k < 3 && k < out_log.size(); k++)
         chk($sformatf("t4_word%0d", k), 64'(out_log[k]), 64'(exp_seq[k]));

      // Disabled node still drains its stored entry and grants nothing.
      out_log.delete();
      i_ready = 1'b0;
      send_chain(32'h44, 2'b11);
      i_en = 1'b0;
      i_chain_valid = 1'b1; i_chain_data_bus = 32'h55;
      i_local_valid = 1'b1; i_local_data_bus = 32'h66;
      @(negedge clk);
      chk("t5_readys", 64'({o_chain_ready, o_local_ready}), 64'd0);
      @(posedge clk); #1;
      i_ready = 1'b1;
      idle(3);
      chk("t5_drained", 64'(o_valid), 64'd0);
      chk("t5_count", 64'(out_log.size()), 64'd1);
      if (out_log.size() != 0) chk("t5_word", 64'(out_log[0]), 64'({32'h44, 3'b110}));
      i_chain_valid = 1'b0; i_local_valid = 1'b0; i_en = 1'b1;
      idle(2);

      // Asynchronous reset with a full buffer discards everything.
      out_log.delete();
      i_ready = 1'b0;
      send_chain(32'h77, 2'b01);
      send_chain(32'h88, 2'b01);
      @(negedge clk);
      chk("t6_full", 64'(o_valid), 64'd1);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("t6_async_valid", 64'(o_valid), 64'd0);
      idle(2);
      rst_n = 1'b1;
      i_ready = 1'b1;
      idle(4);
      chk("t6_no_replay", 64'(out_log.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
